// File: rtl/mdu_issue_ctrl.sv
// Issue controller between the pipeline and a multi-cycle multiply/divide unit.
// Queues START/MT requests in FIFO order and issues them one at a time to the MDU.
module mdu_issue_ctrl #(
    parameter int OPW    = 4,
    parameter int QDEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    input  logic [OPW-1:0] req_op,
    input  logic [31:0]    req_a,
    input  logic [31:0]    req_b,
    output logic           req_ready,
    output logic [OPW-1:0] mdu_op,
    output logic [31:0]    mdu_a,
    output logic [31:0]    mdu_b,
    input  logic           mdu_busy,
    output logic           stall,
    output logic           idle
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            wait_first;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic [OPW-1:0]  q_op [QDEPTH];
    logic [31:0]     q_a  [QDEPTH];
    logic [31:0]     q_b  [QDEPTH];

    logic is_start, is_mt, is_mf, head_start;
    logic full, empty, push, pop;

    assign is_start   = (req_op >= OPW'(1)) && (req_op <= OPW'(4));
    assign is_mt      = (req_op == OPW'(7)) || (req_op == OPW'(8));
    assign is_mf      = (req_op == OPW'(5)) || (req_op == OPW'(6));
    assign head_start = (q_op[rd_ptr] >= OPW'(1)) && (q_op[rd_ptr] <= OPW'(4));

    assign full  = (count == CW'(QDEPTH));
    assign empty = (count == '0);
    assign idle  = empty && (state == S_IDLE) && !mdu_busy;

    // Readiness uses the registered count, so a pop in the same cycle never frees a slot early.
    always_comb begin
        req_ready = 1'b1;
        if (is_start || is_mt)
            req_ready = !full;
        else if (is_mf)
            req_ready = idle;
    end

    assign stall = req_valid && !req_ready;
    assign push  = req_valid && req_ready && (is_start || is_mt);
    assign pop   = (state == S_ISSUE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty && !mdu_busy) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = head_start ? S_WAIT : S_IDLE;
            // The MDU raises busy one cycle after a start, so the first WAIT cycle ignores it.
            S_WAIT:  if (!wait_first && !mdu_busy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mdu_op = pop ? q_op[rd_ptr] : '0;
    assign mdu_a  = pop ? q_a[rd_ptr]  : '0;
    assign mdu_b  = pop ? q_b[rd_ptr]  : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_first <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_nxt;
            wait_first <= (state == S_ISSUE);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr] <= req_op;
            q_a[wr_ptr]  <= req_a;
            q_b[wr_ptr]  <= req_b;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed vector table, a reset-in-WAIT sequence,
// and randomized traffic against a cycle-count based reference model.
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        req_ready;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_a, mdu_b;
    logic        mdu_busy;
    logic        stall, idle;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.OPW(4), .QDEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mdu_op    (mdu_op),
        .mdu_a     (mdu_a),
        .mdu_b     (mdu_b),
        .mdu_busy  (mdu_busy),
        .stall     (stall),
        .idle      (idle)
    );

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
        logic        ready;
        logic        stl;
        logic        idl;
        logic [3:0]  mop;
        logic [31:0] ma;
        logic [31:0] mb;
    } vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic bsy, input logic rdy, input logic stl, input logic idl,
                                input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        vec_t r;
        r.valid = v; r.op = op; r.a = a; r.b = b; r.busy = bsy;
        r.ready = rdy; r.stl = stl; r.idl = idl; r.mop = mop; r.ma = ma; r.mb = mb;
        return r;
    endfunction

    function automatic int op_class(input logic [3:0] op);
        if (op >= 1 && op <= 4) return 1;
        if (op == 7 || op == 8) return 2;
        if (op == 5 || op == 6) return 3;
        return 0;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic bsy);
        req_valid = v; req_op = op; req_a = a; req_b = b; mdu_busy = bsy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic rdy, input logic stl, input logic idl,
                                 input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".stall"},     32'(stall),     32'(stl));
        check({tag, ".idle"},      32'(idle),      32'(idl));
        check({tag, ".mdu_op"},    32'(mdu_op),    32'(mop));
        check({tag, ".mdu_a"},     mdu_a,          ma);
        check({tag, ".mdu_b"},     mdu_b,          mb);
    endtask

    // Reference model state: pending queue plus cycle stamps of the last issue and MDU activity.
    ent_t mq[$];
    bit   m_issuing;
    int   m_wait_start;
    int   cyc;
    int   busy_lo, busy_hi;

    initial begin
        do_reset();

        // Right after reset every class is ready; then the MULT/MTHI/DIV/MFLO/MTLO walk.
        tbl.push_back(mk(0, 4'd1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 4'd5, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 4'd7, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'd1, 3, 5, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'd7, 32'h1234, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd3, 7, 2, 0, 0, 1, 0, 4'd1, 3, 5));
        tbl.push_back(mk(1, 4'd3, 7, 2, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 1, 0, 4'd7, 32'h1234, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 1, 0, 4'd3, 7, 2));
        tbl.push_back(mk(1, 4'd6, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'd11, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4'd8, 9, 32'h55, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, 0, 4'd8, 9, 32'h55));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, 1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].busy);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), tbl[i].ready, tbl[i].stl, tbl[i].idl,
                          tbl[i].mop, tbl[i].ma, tbl[i].mb);
            @(posedge clk);
            #1;
        end

        // Reset asserted in the third WAIT cycle of a MULT with an MTHI still queued.
        drive(1'b1, 4'd1, 32'd11, 32'd12, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 4'd7, 32'hABCD, 32'd0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("rst_seq.issue_op", 32'(mdu_op), 32'd1);
        @(posedge clk); #1;
        mdu_busy = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset    = 1'b1;
        mdu_busy = 1'b0;
        #1;
        check("rst_seq.async_op", 32'(mdu_op), 32'd0);
        check("rst_seq.async_idle", 32'(idle), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_seq.post%0d_op", k), 32'(mdu_op), 32'd0);
            check($sformatf("rst_seq.post%0d_idle", k), 32'(idle), 32'd1);
            @(posedge clk); #1;
        end

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        m_issuing    = 1'b0;
        m_wait_start = -1;
        cyc          = 0;
        busy_lo      = 1;
        busy_hi      = 0;
        for (int n = 0; n < 1500; n++) begin
            logic        v, bsy, exp_idle, exp_ready, nxt;
            logic [3:0]  op;
            logic [31:0] a, b;
            ent_t        e;
            int          c;
            v   = ($urandom_range(0, 3) != 0);
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = $urandom;
            bsy = ($urandom_range(0, 9) == 0) || (cyc >= busy_lo && cyc <= busy_hi);
            drive(v, op, a, b, bsy);

            c = op_class(op);
            exp_idle  = (mq.size() == 0) && !m_issuing && (m_wait_start < 0) && !bsy;
            exp_ready = (c == 1 || c == 2) ? (mq.size() < 2) : (c == 3) ? exp_idle : 1'b1;
            if (m_issuing) e = mq[0];
            else begin e.op = 0; e.a = 0; e.b = 0; end

            @(negedge clk);
            check_outputs($sformatf("rnd%0d", n), exp_ready, v && !exp_ready, exp_idle, e.op, e.a, e.b);
            @(posedge clk); #1;

            nxt = !m_issuing && (m_wait_start < 0) && (mq.size() > 0) && !bsy;
            if (m_wait_start >= 0 && cyc >= m_wait_start + 2 && !bsy) m_wait_start = -1;
            if (m_issuing) begin
                e = mq.pop_front();
                if (op_class(e.op) == 1) begin
                    m_wait_start = cyc;
                    busy_lo      = cyc + 1;
                    busy_hi      = cyc + $urandom_range(1, 6);
                end
            end
            if (v && exp_ready && (c == 1 || c == 2)) begin
                e.op = op; e.a = a; e.b = b;
                mq.push_back(e);
            end
            m_issuing = nxt;
            cyc++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
